// File: rtl/approx_mult_err_accum.sv
// approx_mult_err_accum: error-metric accumulator for an approximate multiplier; optional ERR_SIGNED_SUM_EN adds signed sum output sum_ed
module approx_mult_err_accum #(
  parameter int W         = 16,
  parameter int N_SAMPLES = 10000,
  parameter int CNT_W     = 14,
  parameter int SUM_W     = 30
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     exact,
  input  logic [W-1:0]     apprx,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] err_count,
  output logic [SUM_W-1:0] sum_abs_ed,
  output logic [W-1:0]     max_ed
`ifdef ERR_SIGNED_SUM_EN
  ,
  output logic [SUM_W:0]   sum_ed
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t           state_q, state_d;
  logic             in_ready_q, in_ready_d, busy_q, busy_d, done_q, done_d, drain_q, drain_d;
  logic [CNT_W-1:0] acc_q, acc_d, smp_q, smp_d, err_q, err_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [W-1:0]     max_q, max_d, abs_q, abs_d;
  logic             neq_q, neq_d, s1v_q, s1v_d;
  logic             xfer, clr;
`ifdef ERR_SIGNED_SUM_EN
  logic [W:0]       sd_q, sd_d;
  logic [SUM_W:0]   sed_q, sed_d;
  assign sum_ed = sed_q;
`endif
  assign xfer = in_valid & in_ready_q;
  assign clr  = start & (state_q == IDLE || state_q == DONE);
  assign in_ready     = in_ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign sample_count = smp_q;
  assign err_count    = err_q;
  assign sum_abs_ed   = sum_q;
  assign max_ed       = max_q;
  // Next state, registered status outputs, stage-1 capture and stage-2 accumulation
  always_comb begin
    state_d    = clr ? RUN
               : (state_q == RUN && xfer && acc_q == CNT_W'(N_SAMPLES - 1)) ? DRAIN
               : (state_q == DRAIN && drain_q) ? DONE : state_q;
    drain_d    = (state_q == DRAIN) & ~drain_q;
    in_ready_d = state_d == RUN;
    busy_d     = state_d == RUN || state_d == DRAIN;
    done_d     = state_d == DONE;
    acc_d      = clr ? '0 : acc_q + CNT_W'(xfer);
    abs_d      = exact > apprx ? exact - apprx : apprx - exact;
    neq_d      = exact != apprx;
    s1v_d      = xfer & ~clr;
    smp_d      = clr ? '0 : smp_q + CNT_W'(s1v_q);
    err_d      = clr ? '0 : err_q + CNT_W'(s1v_q & neq_q);
    sum_d      = clr ? '0 : s1v_q ? sum_q + SUM_W'(abs_q) : sum_q;
    max_d      = clr ? '0 : (s1v_q && abs_q > max_q) ? abs_q : max_q;
`ifdef ERR_SIGNED_SUM_EN
    sd_d       = {1'b0, exact} - {1'b0, apprx};
    sed_d      = clr ? '0 : s1v_q ? sed_q + {{(SUM_W - W){sd_q[W]}}, sd_q} : sed_q;
`endif
  end
  // Single state register for FSM, pipeline and accumulators; async reset discards everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      drain_q    <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      acc_q      <= '0;
      abs_q      <= '0;
      neq_q      <= 1'b0;
      s1v_q      <= 1'b0;
      smp_q      <= '0;
      err_q      <= '0;
      sum_q      <= '0;
      max_q      <= '0;
`ifdef ERR_SIGNED_SUM_EN
      sd_q       <= '0;
      sed_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      drain_q    <= drain_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      acc_q      <= acc_d;
      abs_q      <= abs_d;
      neq_q      <= neq_d;
      s1v_q      <= s1v_d;
      smp_q      <= smp_d;
      err_q      <= err_d;
      sum_q      <= sum_d;
      max_q      <= max_d;
`ifdef ERR_SIGNED_SUM_EN
      sd_q       <= sd_d;
      sed_q      <= sed_d;
`endif
    end
  end
endmodule

// File: doc/approx_mult_err_accum.md
Name: approx_mult_err_accum

Overview:
- Hardware error-metric accumulator placed directly downstream of the 8-bit approximate multiplier under test.
- Consumes pairs of (exact, approximate) products over a valid/ready handshake.
- Accumulates error count, sum of absolute error distance, maximum error distance and sample count over a fixed-length run, then holds the results for readout.
- Replaces software-side metric computation for on-chip/FPGA characterisation; MED/ER/MNED are derived off-block from these totals.

Parameters:
- W, 16: product width (exact and apprx).
- N_SAMPLES, 10000: samples per run.
- CNT_W, 14: counter width; must satisfy 2^CNT_W > N_SAMPLES.
- SUM_W, 30: absolute-sum width; W+CNT_W, so it cannot overflow.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a run; sampled only in IDLE or DONE.
- in_valid  in  1  exact/apprx pair valid.
- in_ready  out  1  block accepts a pair.
- exact  in  W  exact product.
- apprx  in  W  approximate product.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  level, high in DONE.
- sample_count  out  CNT_W  pairs accepted this run.
- err_count  out  CNT_W  pairs with exact != apprx.
- sum_abs_ed  out  SUM_W  sum of |exact - apprx|.
- max_ed  out  W  max |exact - apprx| this run.

Behaviour:
- Reset (rst_n low, async): state IDLE; all outputs 0; pipeline valid cleared. Reset mid-run discards everything; no partial results are retained.
- States:
  - IDLE: in_ready=0. start=1 clears all accumulators and the pipeline, then goes to RUN.
  - RUN: in_ready=1. A transfer occurs on a rising edge with in_valid&in_ready=1. On the transfer that makes the accepted count equal N_SAMPLES, go to DRAIN; in_ready is 0 from the next cycle on.
  - DRAIN: in_ready=0. Lasts exactly 2 cycles while the pipeline empties, then goes to DONE.
  - DONE: done=1; results held stable. start=1 clears accumulators and returns to RUN. No other exit except reset.
- start is ignored in RUN and DRAIN. in_valid is ignored outside RUN.
- Pipeline:
  - Stage 1, registered on the transfer edge: abs_d = |exact - apprx| computed unsigned as the larger minus the smaller; neq = (exact != apprx); s1_valid.
  - Stage 2, on the following edge when s1_valid: sample_count += 1; err_count += neq; sum_abs_ed += abs_d; max_ed = abs_d if abs_d > max_ed (strict compare, so ties do not rewrite).
  - Outputs reflect a transfer 2 edges after it. done rises 2 edges after the final transfer, by which point all totals are final.
- Bubbles (in_valid=0) leave the accumulators unchanged. Back-to-back transfers are sustained at 1 per cycle.
- sample_count is driven from the stage-2 counter. The accept counter used for the RUN->DRAIN decision is separate and internal.
- No saturation logic is needed; the widths are sized to be overflow-free.

Optional Feature:
- Macro: ERR_SIGNED_SUM_EN.
- Defined:
  - Adds output port sum_ed (out, SUM_W+1 bits, two's complement) accumulating exact - apprx as a signed value, matching the signed error-distance sum.
  - Stage 1 also registers the signed difference.
  - sum_ed resets to 0 and clears on start, like the other accumulators.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Reset: hold rst_n=0, then release -> all outputs 0, in_ready=0, done=0, busy=0; state IDLE.
2. N_SAMPLES=4; start, then back-to-back pairs (100,100), (200,190), (50,60), (0,0) -> 2 edges after the 4th transfer: done=1, sample_count=4, err_count=2, sum_abs_ed=20, max_ed=10; with ERR_SIGNED_SUM_EN, sum_ed=0.
3. N_SAMPLES=4; in_valid toggles with gaps, and is held high with a 5th pair after the 4th transfer -> in_ready=0 from the cycle after the 4th transfer; 5th pair not counted; sample_count=4.
4. Extremes, N_SAMPLES=2: (65025,0), (0,65535) -> max_ed=65535, sum_abs_ed=130560, err_count=2; with ERR_SIGNED_SUM_EN, sum_ed=-510.
5. N_SAMPLES=4; pulse rst_n low after 2 transfers -> all outputs 0 immediately, IDLE; a new start plus 4 pairs gives correct totals with no residue.
6. In DONE, pulse start -> accumulators 0 next cycle, busy=1, in_ready=1. start pulsed during RUN -> no effect on counts.
